// File: rtl/rotary_pkg.sv
// rotary_pkg: shared state encoding and phase helpers for the rotary emulator and its decoder bench
package rotary_pkg;

    localparam int TMAX = 32;

    typedef enum logic [2:0] {S_OFF, S_ARM, S_IDLE, S_BNC, S_HOLD} state_t;

    // bit i takes bit i+1, bit t-1 takes bit 0: {x[0], x[t-1:1]}
    function automatic logic [TMAX-1:0] rot_right(input logic [TMAX-1:0] x, input int t);
        logic [TMAX-1:0] r;
        r = '0;
        for (int i = 0; i < t; i++) r[i] = x[(i + 1) % t];
        return r;
    endfunction

    // bit i takes bit i-1, bit 0 takes bit t-1: {x[t-2:0], x[t-1]}
    function automatic logic [TMAX-1:0] rot_left(input logic [TMAX-1:0] x, input int t);
        logic [TMAX-1:0] r;
        r = '0;
        for (int i = 0; i < t; i++) r[i] = x[(i + t - 1) % t];
        return r;
    endfunction

    // all lines high except line 0
    function automatic logic [TMAX-1:0] base_phase(input int t);
        logic [TMAX-1:0] r;
        r = '0;
        for (int i = 1; i < t; i++) r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rotary_gen_if.sv
// rotary_gen_if: step request inputs and phase/status outputs of the rotary emulator
interface rotary_gen_if #(
    parameter int T    = 3,
    parameter int QMAX = 7
);
    localparam int PW = $clog2(QMAX + 1) + 1;

    logic                 inc_i;
    logic                 dec_i;
    logic [T-1:0]         rot_no;
    logic signed [PW-1:0] pending_o;
    logic                 busy_o;
    logic                 ovf_o;

    modport master (output inc_i, dec_i, input rot_no, pending_o, busy_o, ovf_o);
    modport slave  (input inc_i, dec_i, output rot_no, pending_o, busy_o, ovf_o);

endinterface

// File: rtl/rotary_stepq.sv
// rotary_stepq: signed saturating count of pending steps; requests beyond +/-QMAX are dropped, consumes never are
module rotary_stepq #(
    parameter int QMAX = 7,
    parameter int PW   = $clog2(QMAX + 1) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 i_inc,
    input  logic                 i_dec,
    input  logic signed [1:0]    i_cons,
    output logic signed [PW-1:0] o_pend,
    output logic                 o_ovf
);
    localparam logic signed [PW:0] L_QMAX = (PW + 1)'(QMAX);

    logic signed [PW-1:0] r_pend;
    logic                 r_ovf;
    logic signed [1:0]    w_req;
    logic signed [PW:0]   w_net;
    logic                 w_drop;

    assign w_req  = (i_inc & ~i_dec) ? 2'sb01 : (i_dec & ~i_inc) ? 2'sb11 : 2'sb00;
    assign w_net  = (PW + 1)'(r_pend) + (PW + 1)'(w_req) - (PW + 1)'(i_cons);
    assign w_drop = (w_net > L_QMAX) || (w_net < -L_QMAX);
    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;

    // apply request and consume together; on overflow keep only the consume
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= w_drop ? r_pend - PW'(i_cons) : w_net[PW-1:0];
            r_ovf  <= w_drop;
        end
    end

endmodule

// File: rtl/rotary_gen.sv
// rotary_gen: turns queued inc/dec requests into a one-cold active-low rotating phase with optional contact bounce
module rotary_gen
    import rotary_pkg::*;
#(
    parameter int T      = 3,
    parameter int HOLD   = 250000,
    parameter int SETTLE = 250000,
    parameter int BOUNCE = 0,
    parameter int GLITCH = 16,
    parameter int QMAX   = 7
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    rotary_gen_if.slave bus
);
    localparam int PW    = $clog2(QMAX + 1) + 1;
    localparam int L_BNC = 2 * BOUNCE * GLITCH;
    localparam int L_A   = HOLD > SETTLE ? HOLD : SETTLE;
    localparam int L_B   = L_BNC > GLITCH ? L_BNC : GLITCH;
    localparam int L_MAX = L_A > L_B ? L_A : L_B;
    localparam int CW    = $clog2(L_MAX + 1);

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [T-1:0]         r_rot;
    logic [T-1:0]         r_tgt;
    logic [T-1:0]         r_old;
    logic signed [PW-1:0] w_pend;
    logic signed [1:0]    w_cons;
    logic [T-1:0]         w_next;
    logic                 w_old_half;

    assign w_cons     = (r_state == S_IDLE && w_pend != '0) ? (w_pend[PW-1] ? 2'sb11 : 2'sb01) : 2'sb00;
    assign w_next     = T'(w_pend[PW-1] ? rot_left(TMAX'(r_rot), T) : rot_right(TMAX'(r_rot), T));
    assign w_old_half = 1'((CW'(L_BNC) - r_cnt) / CW'(GLITCH));

    assign bus.rot_no    = r_rot;
    assign bus.pending_o = w_pend;
    assign bus.busy_o    = (r_state != S_IDLE) || (w_pend != '0);

    rotary_stepq #(.QMAX(QMAX), .PW(PW)) u_stepq (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_inc  (bus.inc_i),
        .i_dec  (bus.dec_i),
        .i_cons (w_cons),
        .o_pend (w_pend),
        .o_ovf  (bus.ovf_o)
    );

    // phase sequencer; r_cnt is the single down-counter timing ARM, BNC and HOLD
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_rot   <= '1;
            r_tgt   <= '1;
            r_old   <= '1;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_state <= S_ARM;
                    r_rot   <= T'(base_phase(T));
                    r_cnt   <= CW'(SETTLE - 1);
                end
                S_ARM: begin
                    if (r_cnt == '0) r_state <= S_IDLE;
                    else r_cnt <= r_cnt - CW'(1);
                end
                S_IDLE: begin
                    if (w_pend != '0) begin
                        r_tgt <= w_next;
                        r_old <= r_rot;
                        r_rot <= w_next;
                        if (BOUNCE > 0) begin
                            r_state <= S_BNC;
                            r_cnt   <= CW'(L_BNC - 1);
                        end else begin
                            r_state <= S_HOLD;
                            r_cnt   <= CW'(HOLD - 1);
                        end
                    end
                end
                S_BNC: begin
                    if (r_cnt == '0) begin
                        r_state <= S_HOLD;
                        r_rot   <= r_tgt;
                        r_cnt   <= CW'(HOLD - 1);
                    end else begin
                        r_rot <= w_old_half ? r_old : r_tgt;
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) r_state <= S_IDLE;
                    else r_cnt <= r_cnt - CW'(1);
                end
                default: r_state <= S_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_rotary_gen.sv
// tb_rotary_gen: clean and bouncing emulators checked against a queue-based phase model
module tb_rotary_gen;
    localparam int T = 3, HOLD = 4, SETTLE = 8, GLITCH = 2, QMAX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;

    rotary_gen_if #(.T(T), .QMAX(QMAX)) b0 ();
    rotary_gen_if #(.T(T), .QMAX(QMAX)) b2 ();

    rotary_gen #(.T(T), .HOLD(HOLD), .SETTLE(SETTLE), .BOUNCE(0), .GLITCH(GLITCH), .QMAX(QMAX)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b0));
    rotary_gen #(.T(T), .HOLD(HOLD), .SETTLE(SETTLE), .BOUNCE(2), .GLITCH(GLITCH), .QMAX(QMAX)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b2));

    always #5 clk = ~clk;

    logic [7:0] a_vec [2];
    assign a_vec[0] = {b0.rot_no, b0.pending_o, b0.busy_o, b0.ovf_o};
    assign a_vec[1] = {b2.rot_no, b2.pending_o, b2.busy_o, b2.ovf_o};

    // model: low-line index, integer backlog, and a queue of phase values still to be shown
    logic [2:0] m_rot [2];
    int         m_ph [2];
    int         m_pend [2];
    logic       m_ovf [2];
    logic       m_idle [2];
    logic [2:0] m_q [2][$];

    function automatic logic [7:0] m_vec(input int k);
        return {m_rot[k], 3'(m_pend[k]), (!m_idle[k] || m_pend[k] != 0), m_ovf[k]};
    endfunction

    function automatic void model_step(input int k, input logic inc, input logic dec);
        int req, cons, net, nb;
        logic [2:0] tgt, old;
        cons = 0;
        if (!rst_n) begin
            m_rot[k] = 3'b111;
            m_ph[k] = 0;
            m_pend[k] = 0;
            m_ovf[k] = 1'b0;
            m_idle[k] = 1'b0;
            m_q[k].delete();
            for (int i = 0; i < SETTLE; i++) m_q[k].push_back(3'b110);
            return;
        end
        if (m_idle[k] && m_pend[k] != 0) begin
            cons = (m_pend[k] > 0) ? 1 : -1;
            m_ph[k] = (m_ph[k] + T - cons) % T;
            old = m_rot[k];
            tgt = ~(3'b001 << m_ph[k]);
            nb = (k == 1) ? 2 : 0;
            for (int b = 0; b < nb; b++) begin
                for (int g = 0; g < GLITCH; g++) m_q[k].push_back(tgt);
                for (int g = 0; g < GLITCH; g++) m_q[k].push_back(old);
            end
            for (int h = 0; h < HOLD; h++) m_q[k].push_back(tgt);
            m_idle[k] = 1'b0;
        end else if (m_q[k].size() == 0) begin
            m_idle[k] = 1'b1;
        end
        if (m_q[k].size() > 0) m_rot[k] = m_q[k].pop_front();
        req = (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
        net = m_pend[k] + req - cons;
        if (net > QMAX || net < -QMAX) begin
            m_pend[k] = m_pend[k] - cons;
            m_ovf[k] = 1'b1;
        end else begin
            m_pend[k] = net;
            m_ovf[k] = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        model_step(0, b0.inc_i, b0.dec_i);
        model_step(1, b2.inc_i, b2.dec_i);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (a_vec[0] !== 8'b111_000_1_0) begin
            n_err++;
            $display("FAIL reset_state got %b exp %b", a_vec[0], 8'b111_000_1_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++;
            if (a_vec[0] !== {3'b110, 3'b000, (c < 8), 1'b0}) begin
                n_err++;
                $display("FAIL arm_seq c=%0d got %b exp %b", c, a_vec[0], {3'b110, 3'b000, (c < 8), 1'b0});
            end
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (a_vec[k] !== m_vec(k)) begin
                    n_err++;
                    $display("FAIL reset_model dut%0d t=%0t got %b exp %b", k, $time, a_vec[k], m_vec(k));
                end
            end
        end
    endtask

    task automatic test_steps();
        logic [2:0] seen[$];
        int at[$];
        logic [2:0] prev;
        logic [2:0] exp_s [3];
        exp_s = '{3'b011, 3'b101, 3'b110};
        prev = b0.rot_no;
        b0.inc_i = 1'b1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (a_vec[k] !== m_vec(k)) begin
                    n_err++;
                    $display("FAIL steps_model dut%0d t=%0t got %b exp %b", k, $time, a_vec[k], m_vec(k));
                end
            end
            if (b0.rot_no !== prev) begin
                seen.push_back(b0.rot_no);
                at.push_back(c);
                prev = b0.rot_no;
            end
            if (c == 2) b0.inc_i = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= seen.size() || seen[i] !== exp_s[i] || (i > 0 && at[i] - at[i-1] != HOLD + 1)) begin
                n_err++;
                $display("FAIL inc_step%0d got %b (n=%0d) exp %b every %0d cycles", i, (i < seen.size()) ? seen[i] : 3'bxxx, seen.size(), exp_s[i], HOLD + 1);
            end
        end
        n_vec++;
        if (b0.pending_o !== 3'sd0 || seen.size() != 3) begin
            n_err++;
            $display("FAIL inc_drain pending got %0d steps %0d exp 0 and 3", b0.pending_o, seen.size());
        end
    endtask

    task automatic test_dec_cancel();
        logic [2:0] seen[$];
        logic [2:0] prev;
        prev = b0.rot_no;
        b0.dec_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (a_vec[k] !== m_vec(k)) begin
                    n_err++;
                    $display("FAIL dec_model dut%0d t=%0t got %b exp %b", k, $time, a_vec[k], m_vec(k));
                end
            end
            if (b0.rot_no !== prev) begin
                seen.push_back(b0.rot_no);
                prev = b0.rot_no;
            end
            if (c == 1) b0.dec_i = 1'b0;
        end
        n_vec++;
        if (seen.size() != 2 || seen[0] !== 3'b101 || seen[1] !== 3'b011) begin
            n_err++;
            $display("FAIL dec_steps got n=%0d %b %b exp 101 011", seen.size(), seen[0], seen[1]);
        end
        b0.inc_i = 1'b1;
        b0.dec_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (b0.rot_no !== 3'b011 || b0.pending_o !== 3'sd0 || b0.busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL cancel c=%0d got rot %b pend %0d busy %b exp 011 0 0", c, b0.rot_no, b0.pending_o, b0.busy_o);
            end
        end
        b0.inc_i = 1'b0;
        b0.dec_i = 1'b0;
    endtask

    task automatic test_saturate();
        int n_ovf, n_chg, mx;
        logic [2:0] prev;
        n_ovf = 0;
        n_chg = 0;
        mx = 0;
        prev = 3'b110;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        b0.inc_i = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (a_vec[k] !== m_vec(k)) begin
                    n_err++;
                    $display("FAIL sat_model dut%0d t=%0t got %b exp %b", k, $time, a_vec[k], m_vec(k));
                end
            end
            if (b0.ovf_o === 1'b1) n_ovf++;
            if (b0.rot_no !== prev) n_chg++;
            prev = b0.rot_no;
            if (int'(b0.pending_o) > mx) mx = int'(b0.pending_o);
            if (c == 4) b0.inc_i = 1'b0;
        end
        n_vec++;
        if (n_ovf != 2 || n_chg != 3 || mx != QMAX || b0.pending_o !== 3'sd0) begin
            n_err++;
            $display("FAIL saturate got ovf %0d steps %0d max %0d end %0d exp 2 3 %0d 0", n_ovf, n_chg, mx, b0.pending_o, QMAX);
        end
    endtask

    task automatic test_bounce();
        logic [2:0] exp_b [12];
        exp_b = '{3'b011, 3'b011, 3'b110, 3'b110, 3'b011, 3'b011, 3'b110, 3'b110, 3'b011, 3'b011, 3'b011, 3'b011};
        b2.inc_i = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (a_vec[k] !== m_vec(k)) begin
                    n_err++;
                    $display("FAIL bnc_model dut%0d t=%0t got %b exp %b", k, $time, a_vec[k], m_vec(k));
                end
            end
            if (c >= 1 && c <= 12) begin
                n_vec++;
                if (b2.rot_no !== exp_b[c-1]) begin
                    n_err++;
                    $display("FAIL bounce_seq c=%0d got %b exp %b", c, b2.rot_no, exp_b[c-1]);
                end
            end
            if (c == 0) b2.inc_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_hold();
        b0.inc_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (a_vec[k] !== m_vec(k)) begin
                    n_err++;
                    $display("FAIL mid_model dut%0d t=%0t got %b exp %b", k, $time, a_vec[k], m_vec(k));
                end
            end
        end
        n_vec++;
        if (b0.pending_o !== 3'sd2 || b0.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pending got %0d busy %b exp 2 1", b0.pending_o, b0.busy_o);
        end
        b0.inc_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (a_vec[0] !== 8'b111_000_1_0) begin
            n_err++;
            $display("FAIL mid_abort got %b exp %b", a_vec[0], 8'b111_000_1_0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (a_vec[k] !== m_vec(k)) begin
                    n_err++;
                    $display("FAIL rearm_model dut%0d t=%0t got %b exp %b", k, $time, a_vec[k], m_vec(k));
                end
            end
        end
        n_vec++;
        if (b0.rot_no !== 3'b110 || b0.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rearm got rot %b busy %b exp 110 0", b0.rot_no, b0.busy_o);
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (a_vec[k] !== m_vec(k)) begin
                    n_err++;
                    $display("FAIL rand_model dut%0d t=%0t got %b exp %b", k, $time, a_vec[k], m_vec(k));
                end
            end
            rst_n = ($urandom_range(0, 149) != 0);
            r = $urandom_range(0, 7);
            b0.inc_i = (c < 400) ? (r < 2 || r == 3) : (r == 2 || r == 3);
            b0.dec_i = (c < 400) ? (r == 2 || r == 3) : (r < 2 || r == 3);
            r = $urandom_range(0, 7);
            b2.inc_i = (c >= 400) ? (r < 2 || r == 3) : (r == 2 || r == 3);
            b2.dec_i = (c >= 400) ? (r == 2 || r == 3) : (r < 2 || r == 3);
        end
        rst_n = 1'b1;
        b0.inc_i = 1'b0;
        b0.dec_i = 1'b0;
        b2.inc_i = 1'b0;
        b2.dec_i = 1'b0;
    endtask

    initial begin
        b0.inc_i = 1'b0;
        b0.dec_i = 1'b0;
        b2.inc_i = 1'b0;
        b2.dec_i = 1'b0;
        test_reset();
        test_steps();
        test_dec_cancel();
        test_saturate();
        test_bounce();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rotary_gen.md
Name: rotary_gen

Overview:
Rotary-encoder emulator: converts inc/dec step requests into the T-phase, active-low, one-cold rotating pattern that our rotary decoder consumes. Sits in front of the decoder's rot_ni input, either in the bench or as a loop-back source on board. Optional contact-bounce injection exercises the decoder's debounce path. Pending steps are queued and replayed at a programmable phase rate.

Parameters:
T, 3, number of phase lines (>=3)
HOLD, 250000, cycles each phase is held stable after a step (>200000 so the decoder accepts it)
SETTLE, 250000, cycles the base phase is held after reset release, before stepping starts
BOUNCE, 0, glitch pairs injected per transition (0 = clean edges)
GLITCH, 16, cycles per glitch half-period
QMAX, 7, magnitude limit of the pending-step queue

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock; reset is synchronous and active-low
inc_i  in  1  request one increment step (sampled each cycle)
dec_i  in  1  request one decrement step
rot_no  out  T  active-low phase lines to decoder
pending_o  out  $clog2(QMAX+1)+1  signed queued steps (+ = inc)
busy_o  out  1  high when state!=IDLE or pending!=0
ovf_o  out  1  one-cycle pulse when a request is dropped at saturation

Behaviour:
- Reset (rst_ni low at an edge): rot_no={T{1}}, pending=0, ovf_o=0, state OFF; busy_o high. Reset mid-step aborts immediately; no partial phase survives.
- States: OFF -> ARM -> IDLE <-> (BNC) -> HOLD -> IDLE.
- OFF: one cycle after reset release, then ARM.
- ARM: rot_no=base phase (all ones, bit0 low; T=3 -> 3'b110) for exactly SETTLE cycles, then IDLE. Requests are queued during ARM.
- IDLE: pending>0 -> target=rotate-right(rot_no)={x[0],x[T-1:1]}, consume +1. pending<0 -> target=rotate-left(rot_no)={x[T-2:0],x[T-1]}, consume -1. Go to BNC if BOUNCE>0, else drive target and go to HOLD. rot_no changes on the edge after IDLE sees pending!=0 (1-cycle latency).
- BNC: drive target for GLITCH cycles, then the old phase for GLITCH cycles, repeated BOUNCE times; then drive target and go to HOLD.
- HOLD: target stable for exactly HOLD cycles, then IDLE. Minimum clean step period is HOLD+1 cycles.
- rot_no is always one-cold outside OFF. It never shows all-ones or multiple low bits after ARM.
- Queue update per cycle: req = +1 (inc_i&~dec_i), -1 (dec_i&~inc_i), else 0 (both or neither cancel). Net = pending + req - consumed.
- If |net| > QMAX, the request is dropped: pending = pending - consumed, and ovf_o pulses. A consume is never dropped.
- pending is two's-complement. QMAX must fit, so there is no wrap-around.
- Direction reversal: queued +2 followed by three dec requests nets -1. Only net steps are emitted; each emitted step sees the current phase.

Decomposition:
- Package rotary_pkg: state enum (OFF, ARM, IDLE, BNC, HOLD), rotate-left and rotate-right functions parameterised on T, base-phase constant function. Shared with the decoder bench.
- Sub-module rotary_stepq: signed saturating pending counter with consume input and ovf pulse.
- One shared down-counter in the top module serves ARM, BNC and HOLD.

Test Plan (T=3, HOLD=4, SETTLE=8, BOUNCE=0, GLITCH=2, QMAX=3 unless stated):
- Reset release, no requests -> rot_no 111 for 1 cycle, then 110 for 8 cycles, busy_o falls, rot_no stays 110.
- One inc pulse in IDLE -> rot_no 011 next cycle, held 4 cycles. Three incs total -> 011, 101, 110, each 5 cycles apart; pending returns to 0.
- Two decs -> 101 then 011. Simultaneous inc&dec for 5 cycles -> pending unchanged, no phase change.
- Five inc pulses during ARM -> pending saturates at 3, ovf_o pulses twice, exactly 3 steps emitted.
- BOUNCE=2: one inc -> rot_no 011,011,110,110,011,011,110,110, then 011 held 4 cycles.
- rst_ni low during HOLD with pending=2 -> next cycle rot_no=111, pending=0; re-arms to 110.
